bus_arbiter: RTL and testbench

Two-master, single-slave-port arbiter that sits directly downstream of the execute stage's load/store unit and the fetch unit, and drives the shared system bus (ROM, SRAM, UART, external RAM chip enables). It grants the bus to one master at a time with round-robin fairness, holds ownership until the selected slave acknowledges, and returns `gnt` in the data-valid cycle. A master's stall is therefore `req & ~gnt`. A watchdog terminates transactions that receive no acknowledge.

---
 rtl/bus_arbiter_if.sv | 44 ++++
 rtl/bus_arbiter.sv | 101 ++++++++++
 tb/tb_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Signal bundle linking the fetch and LSU masters, the arbiter and the shared system bus.
// slave is the arbiter's view; master is the view of the requesting units and the bus slave.
interface bus_arbiter_if;
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic [7:0]  m0_ce_i;
    logic        m0_gnt_o;

    logic        m1_req_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_we_i;
    logic [1:0]  m1_hb_i;
    logic [7:0]  m1_ce_i;
    logic        m1_gnt_o;

    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_we_o;
    logic [1:0]  bus_hb_o;
    logic [7:0]  bus_ce_o;
    logic        bus_ack_i;

    logic        owner_o;
    logic        err_o;

    modport slave (
        input  m0_req_i, m0_addr_i, m0_ce_i,
        input  m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_hb_i, m1_ce_i,
        input  bus_ack_i,
        output m0_gnt_o, m1_gnt_o,
        output bus_addr_o, bus_wdata_o, bus_we_o, bus_hb_o, bus_ce_o,
        output owner_o, err_o
    );

    modport master (
        output m0_req_i, m0_addr_i, m0_ce_i,
        output m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_hb_i, m1_ce_i,
        output bus_ack_i,
        input  m0_gnt_o, m1_gnt_o,
        input  bus_addr_o, bus_wdata_o, bus_we_o, bus_hb_o, bus_ce_o,
        input  owner_o, err_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between fetch (m0) and LSU (m1) for the shared system bus,
// with a watchdog that force-completes transactions the slave never acknowledges.
//
// state   | meaning
// ST_IDLE | no owner; bus parked at 0, valid requests arbitrated
// ST_BUSY | owner drives the bus until ack, request drop or watchdog expiry
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bus_arbiter_if.slave bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_BUSY   = 1'b1;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [0:0] r_state;
    logic       r_owner;
    logic       r_last;
    logic [7:0] r_wait_cnt;

    logic        w_m0_valid;
    logic        w_m1_valid;
    logic        w_pick_m1;
    logic        w_busy;
    logic        w_own_valid;
    logic        w_ack_done;
    logic        w_timeout;
    logic        w_grant;
    logic        w_abort;
    logic [31:0] w_addr;
    logic [7:0]  w_ce;

    assign w_m0_valid = bus.m0_req_i & (|bus.m0_ce_i);
    assign w_m1_valid = bus.m1_req_i & (|bus.m1_ce_i);

    // On a tie the master that did not win last time gets the bus.
    assign w_pick_m1 = w_m1_valid & (~w_m0_valid | ~r_last);

    // Reset masks everything so a transaction caught by reset never sees a grant.
    assign w_busy      = (r_state == ST_BUSY) & ~rst_i;
    assign w_own_valid = r_owner ? w_m1_valid : w_m0_valid;
    assign w_ack_done  = w_busy & w_own_valid & bus.bus_ack_i;
    assign w_timeout   = w_busy & w_own_valid & ~bus.bus_ack_i & (r_wait_cnt == WAIT_LAST);
    assign w_grant     = w_ack_done | w_timeout;
    assign w_abort     = w_busy & ~w_own_valid;

    assign w_addr = r_owner ? bus.m1_addr_i : bus.m0_addr_i;
    assign w_ce   = r_owner ? (bus.m1_ce_i & {8{bus.m1_req_i}})
                            : (bus.m0_ce_i & {8{bus.m0_req_i}});

    assign bus.bus_addr_o  = w_busy ? w_addr : 32'd0;
    assign bus.bus_wdata_o = (w_busy & r_owner) ? bus.m1_wdata_i : 32'd0;
    assign bus.bus_we_o    = w_busy & r_owner & bus.m1_we_i;
    assign bus.bus_hb_o    = (w_busy & r_owner) ? bus.m1_hb_i : 2'b00;
    // A timed-out access is withdrawn from the slave while the master is released.
    assign bus.bus_ce_o    = (w_busy & ~w_timeout) ? w_ce : 8'd0;

    assign bus.m0_gnt_o = w_grant & ~r_owner;
    assign bus.m1_gnt_o = w_grant & r_owner;
    assign bus.owner_o  = w_busy & r_owner;
    assign bus.err_o    = w_timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wait_cnt <= 8'd0;
                    if (w_m0_valid | w_m1_valid) begin
                        r_state <= ST_BUSY;
                        r_owner <= w_pick_m1;
                    end
                end
                ST_BUSY: begin
                    if (w_grant) begin
                        r_state    <= ST_IDLE;
                        r_last     <= r_owner;
                        r_wait_cnt <= 8'd0;
                    end else if (w_abort) begin
                        r_state    <= ST_IDLE;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized master/slave traffic,
// every cycle compared against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int TO = 4;

    logic clk_i = 1'b0;
    logic rst_i;

    bus_arbiter_if u_if ();

    bus_arbiter #(.TIMEOUT(TO)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (u_if)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: who holds the bus (-1 = nobody), cycles spent unacknowledged, who wins the next tie.
    int m_owner = -1;
    int m_waited = 0;
    int m_tie = 0;
    bit p_gnt [2];

    logic        s_gnt0, s_gnt1, s_err, s_we, s_owner;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_hb;
    logic [7:0]  s_ce;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_m0(input logic req, input logic [31:0] addr, input logic [7:0] ce);
        u_if.m0_req_i  = req;
        u_if.m0_addr_i = addr;
        u_if.m0_ce_i   = ce;
    endtask

    task automatic set_m1(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic [1:0] hb, input logic [7:0] ce);
        u_if.m1_req_i   = req;
        u_if.m1_addr_i  = addr;
        u_if.m1_wdata_i = wdata;
        u_if.m1_we_i    = we;
        u_if.m1_hb_i    = hb;
        u_if.m1_ce_i    = ce;
    endtask

    // One clock: settle, compare every output with the model, snapshot, advance both.
    task automatic cycle();
        bit          v0, v1, vo;
        int          o, n_owner, n_waited, n_tie;
        logic        e_gnt0, e_gnt1, e_err, e_we, e_owner;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_hb;
        logic [7:0]  e_ce, ce_o;
        #3;
        v0 = u_if.m0_req_i && (u_if.m0_ce_i != 8'd0);
        v1 = u_if.m1_req_i && (u_if.m1_ce_i != 8'd0);
        {e_gnt0, e_gnt1, e_err, e_we, e_owner} = '0;
        e_addr = '0; e_wdata = '0; e_hb = '0; e_ce = '0;
        n_owner = m_owner; n_waited = m_waited; n_tie = m_tie;
        if (rst_i) begin
            n_owner = -1; n_waited = 0; n_tie = 0;
        end else if (m_owner < 0) begin
            if (v0 && v1) n_owner = m_tie;
            else if (v0)  n_owner = 0;
            else if (v1)  n_owner = 1;
            n_waited = 0;
        end else begin
            o  = m_owner;
            vo = (o == 1) ? v1 : v0;
            ce_o    = (o == 1) ? u_if.m1_ce_i : u_if.m0_ce_i;
            e_owner = (o == 1);
            e_addr  = (o == 1) ? u_if.m1_addr_i : u_if.m0_addr_i;
            if (o == 1) begin
                e_wdata = u_if.m1_wdata_i;
                e_we    = u_if.m1_we_i;
                e_hb    = u_if.m1_hb_i;
            end
            if (!vo) begin
                n_owner = -1;
            end else if (u_if.bus_ack_i || m_waited == TO - 1) begin
                e_gnt0  = (o == 0);
                e_gnt1  = (o == 1);
                e_err   = !u_if.bus_ack_i;
                e_ce    = e_err ? 8'd0 : ce_o;
                n_owner = -1;
                n_tie   = 1 - o;
            end else begin
                e_ce     = ce_o;
                n_waited = m_waited + 1;
            end
        end
        s_gnt0 = u_if.m0_gnt_o;  s_gnt1 = u_if.m1_gnt_o;  s_err = u_if.err_o;
        s_addr = u_if.bus_addr_o; s_wdata = u_if.bus_wdata_o; s_we = u_if.bus_we_o;
        s_hb = u_if.bus_hb_o;     s_ce = u_if.bus_ce_o;       s_owner = u_if.owner_o;
        chk("m0_gnt", 32'(s_gnt0), 32'(e_gnt0));
        chk("m1_gnt", 32'(s_gnt1), 32'(e_gnt1));
        chk("err", 32'(s_err), 32'(e_err));
        chk("addr", s_addr, e_addr);
        chk("wdata", s_wdata, e_wdata);
        chk("we", 32'(s_we), 32'(e_we));
        chk("hb", 32'(s_hb), 32'(e_hb));
        chk("ce", 32'(s_ce), 32'(e_ce));
        chk("owner", 32'(s_owner), 32'(e_owner));
        p_gnt[0] = e_gnt0;
        p_gnt[1] = e_gnt1;
        @(posedge clk_i);
        m_owner = n_owner; m_waited = n_waited; m_tie = n_tie;
        #1;
    endtask

    task automatic idle_inputs();
        set_m0(1'b0, 32'd0, 8'd0);
        set_m1(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 8'd0);
        u_if.bus_ack_i = 1'b0;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        idle_inputs();
        cycle();
        cycle();
        rst_i = 1'b0;
    endtask

    bit          act [2];
    logic [31:0] r_addr [2];
    logic [7:0]  r_ce [2];
    logic [31:0] r_wdata;
    logic        r_we;
    logic [1:0]  r_hb;

    initial begin
        idle_inputs();
        rst_i = 1'b1;

        // Reset, then a single zero-wait fetch.
        reset_dut();
        chk("rst_ce", 32'(s_ce), 32'd0);
        set_m0(1'b1, 32'h100, 8'h01);
        cycle();
        chk("t1_idle_addr", s_addr, 32'd0);
        u_if.bus_ack_i = 1'b1;
        cycle();
        chk("t1_addr", s_addr, 32'h100);
        chk("t1_gnt0", 32'(s_gnt0), 32'd1);
        set_m0(1'b0, 32'h100, 8'h01);
        u_if.bus_ack_i = 1'b0;
        cycle();
        chk("t1_bubble_ce", 32'(s_ce), 32'd0);

        // Zero chip-enable request is never arbitrated.
        set_m0(1'b1, 32'h55, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("zce_addr", s_addr, 32'd0);
        end

        // Both masters continuously, zero-wait slave: strict alternation, m0 first.
        reset_dut();
        set_m0(1'b1, 32'h1000, 8'h01);
        set_m1(1'b1, 32'h2000, 32'h12345678, 1'b0, 2'b10, 8'h02);
        u_if.bus_ack_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_gnt0", 32'(s_gnt0), 32'(i % 4 == 1));
            chk("rr_gnt1", 32'(s_gnt1), 32'(i % 4 == 3));
        end

        // LSU write with a 3-wait-state slave, fetch waiting behind it.
        reset_dut();
        set_m1(1'b1, 32'h2004, 32'hDEADBEEF, 1'b1, 2'b01, 8'h02);
        cycle();
        set_m0(1'b1, 32'h300, 8'h01);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("t3_addr", s_addr, 32'h2004);
            chk("t3_wdata", s_wdata, 32'hDEADBEEF);
            chk("t3_hb", 32'(s_hb), 32'h1);
            chk("t3_ce", 32'(s_ce), 32'h02);
            chk("t3_gnt", 32'({s_gnt0, s_gnt1}), 32'd0);
        end
        u_if.bus_ack_i = 1'b1;
        cycle();
        chk("t3_gnt1", 32'(s_gnt1), 32'd1);
        chk("t3_gnt0", 32'(s_gnt0), 32'd0);
        chk("t3_err", 32'(s_err), 32'd0);
        idle_inputs();
        cycle();

        // Watchdog expiry, then the next tie goes to m1.
        reset_dut();
        set_m0(1'b1, 32'h40, 8'h04);
        cycle();
        for (int i = 1; i < TO; i++) begin
            cycle();
            chk("t4_wait_gnt0", 32'(s_gnt0), 32'd0);
            chk("t4_wait_err", 32'(s_err), 32'd0);
        end
        cycle();
        chk("t4_gnt0", 32'(s_gnt0), 32'd1);
        chk("t4_err", 32'(s_err), 32'd1);
        chk("t4_ce", 32'(s_ce), 32'd0);
        set_m1(1'b1, 32'h44, 32'h0, 1'b0, 2'b00, 8'h08);
        cycle();
        u_if.bus_ack_i = 1'b1;
        cycle();
        chk("t4_tie_gnt1", 32'(s_gnt1), 32'd1);
        chk("t4_tie_gnt0", 32'(s_gnt0), 32'd0);
        idle_inputs();
        cycle();

        // LSU aborts in its second BUSY cycle; pending fetch wins next.
        reset_dut();
        set_m1(1'b1, 32'h500, 32'h0, 1'b0, 2'b00, 8'h10);
        cycle();
        set_m0(1'b1, 32'h600, 8'h01);
        cycle();
        chk("t5_owner", 32'(s_owner), 32'd1);
        set_m1(1'b0, 32'h500, 32'h0, 1'b0, 2'b00, 8'h10);
        cycle();
        chk("t5_gnt1", 32'(s_gnt1), 32'd0);
        chk("t5_err", 32'(s_err), 32'd0);
        chk("t5_ce", 32'(s_ce), 32'd0);
        cycle();
        u_if.bus_ack_i = 1'b1;
        cycle();
        chk("t5_gnt0", 32'(s_gnt0), 32'd1);
        idle_inputs();
        cycle();

        // Reset in the middle of a transaction with ack pending.
        reset_dut();
        set_m0(1'b1, 32'h700, 8'h01);
        u_if.bus_ack_i = 1'b1;
        cycle();
        cycle();
        set_m0(1'b0, 32'h700, 8'h01);
        set_m1(1'b1, 32'h800, 32'hA5A5A5A5, 1'b1, 2'b11, 8'h20);
        u_if.bus_ack_i = 1'b0;
        cycle();
        cycle();
        rst_i = 1'b1;
        u_if.bus_ack_i = 1'b1;
        cycle();
        chk("t6_gnt1", 32'(s_gnt1), 32'd0);
        chk("t6_addr", s_addr, 32'd0);
        chk("t6_ce", 32'(s_ce), 32'd0);
        rst_i = 1'b0;
        set_m0(1'b1, 32'h900, 8'h01);
        u_if.bus_ack_i = 1'b0;
        cycle();
        chk("t6_idle_ce", 32'(s_ce), 32'd0);
        u_if.bus_ack_i = 1'b1;
        cycle();
        chk("t6_tie_gnt0", 32'(s_gnt0), 32'd1);
        chk("t6_tie_gnt1", 32'(s_gnt1), 32'd0);

        // Randomized traffic: masters hold requests until granted or aborted.
        idle_inputs();
        act[0] = 1'b0;
        act[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 2; k++) begin
                if (p_gnt[k]) act[k] = 1'b0;
                if (act[k] && $urandom_range(0, 24) == 0) act[k] = 1'b0;
                if (!act[k] && $urandom_range(0, 1) == 1) begin
                    act[k]    = 1'b1;
                    r_addr[k] = $urandom;
                    r_ce[k]   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                    if (k == 1) begin
                        r_wdata = $urandom;
                        r_we    = 1'($urandom_range(0, 1));
                        r_hb    = 2'($urandom_range(0, 3));
                    end
                end
            end
            set_m0(act[0], r_addr[0], r_ce[0]);
            set_m1(act[1], r_addr[1], r_wdata, r_we, r_hb, r_ce[1]);
            u_if.bus_ack_i = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
